// File: rtl/ahb_sub_mem.sv
// AHB-Lite subordinate memory: word-addressed byte-lane RAM behind a small FSM that
// inserts programmable wait states and returns a two-cycle ERROR for illegal transfers.
module ahb_sub_mem #(
    parameter int unsigned ADDRWIDTH    = 32,
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned MEMWORDSLOG2 = 12,
    parameter logic [31:0] BASEADDR     = 32'h0000_0000,
    parameter int unsigned NSEQWAIT     = 0,
    parameter int unsigned SEQWAIT      = 0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   hsel,
    input  logic [ADDRWIDTH-1:0]   haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [2:0]             hburst,
    input  logic [DATAWIDTH-1:0]   hwdata,
    input  logic [DATAWIDTH/8-1:0] hwstrb,
    input  logic                   hready,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [DATAWIDTH-1:0]   hrdata
);

    localparam int unsigned IDXW     = MEMWORDSLOG2;
    localparam int unsigned DEPTH    = 1 << MEMWORDSLOG2;
    localparam int unsigned NLANES   = DATAWIDTH / 8;
    localparam logic [3:0]  NSEQ_CNT = 4'(NSEQWAIT);
    localparam logic [3:0]  SEQ_CNT  = 4'(SEQWAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              state_reg;
    state_t              launch_state;
    logic [3:0]          cnt_reg;
    logic [3:0]          launch_cnt;
    logic [IDXW-1:0]     index_reg;
    logic                write_reg;
    logic                hreadyout_reg;
    logic                hresp_reg;
    logic                accept;
    logic                addr_err;
    logic [ADDRWIDTH-1:0] offset;
    logic                rd_active;
    logic                wr_active;
    logic [DATAWIDTH-1:0] rd_word;
    logic                unused_bits;

    // The window is aligned to its size, so an address below BASEADDR wraps to a
    // large offset and is caught by the same upper-bits test as one above the window.
    assign offset     = haddr - BASEADDR[ADDRWIDTH-1:0];
    assign accept     = hsel & hready & htrans[1];
    assign addr_err   = (offset[ADDRWIDTH-1:IDXW+2] != '0) | (hsize != 3'b010) |
                        (haddr[1:0] != 2'b00);
    assign launch_cnt = (htrans == 2'b11) ? SEQ_CNT : NSEQ_CNT;

    always_comb begin
        launch_state = ST_IDLE;
        if (accept) begin
            if (addr_err) begin
                launch_state = ST_ERR1;
            end else if (launch_cnt != 4'd0) begin
                launch_state = ST_WAIT;
            end else begin
                launch_state = ST_DATA;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            index_reg     <= '0;
            write_reg     <= 1'b0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    if (cnt_reg == 4'd1) begin
                        state_reg     <= ST_DATA;
                        hreadyout_reg <= 1'b1;
                    end
                    cnt_reg <= cnt_reg - 4'd1;
                end
                ST_ERR1: begin
                    state_reg     <= ST_ERR2;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all end with hreadyout=1, so a new address phase may land here
                    state_reg     <= launch_state;
                    cnt_reg       <= launch_cnt;
                    hreadyout_reg <= !((launch_state == ST_WAIT) || (launch_state == ST_ERR1));
                    hresp_reg     <= (launch_state == ST_ERR1);
                    if (accept) begin
                        index_reg <= offset[IDXW+1:2];
                        write_reg <= hwrite;
                    end
                end
            endcase
        end
    end

    assign rd_active = (state_reg == ST_DATA) && !write_reg;
    assign wr_active = (state_reg == ST_DATA) && write_reg;

    // One byte-wide array per lane so strobed writes never share a storage element.
    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge hclk) begin
                if (wr_active && hwstrb[gi]) begin
                    lane_mem[index_reg] <= hwdata[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[index_reg];
        end
    endgenerate

    assign hreadyout   = hreadyout_reg;
    assign hresp       = hresp_reg;
    assign hrdata      = rd_active ? rd_word : '0;
    assign unused_bits = ^{hburst, offset[1:0]};

endmodule

// File: tb/tb_ahb_sub_mem.sv
// Directed bench for ahb_sub_mem: a zero-wait instance and a 2/1 wait-state instance
// share one pipelined AHB manager driver; each test task checks its own results.
module tb_ahb_sub_mem;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] SZ_HALF  = 3'b001;
    localparam logic [2:0] SZ_WORD  = 3'b010;
    localparam int         MAXB     = 12;

    logic        hclk;
    logic        hresetn;
    logic        hsel_drv;
    logic        dsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        hsel0, hsel1;
    logic        ro0, ro1, rp0, rp1;
    logic [31:0] rd0, rd1;
    logic        hready;
    logic        hresp_m;
    logic [31:0] hrdata_m;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] b_addr  [MAXB];
    logic        b_write [MAXB];
    logic [1:0]  b_trans [MAXB];
    logic [2:0]  b_size  [MAXB];
    logic [31:0] b_wdata [MAXB];
    logic [3:0]  b_strb  [MAXB];
    logic [31:0] r_rdata [MAXB];
    logic        r_resp  [MAXB];
    logic        r_err1  [MAXB];
    int          r_waits [MAXB];

    assign hsel0    = hsel_drv && !dsel;
    assign hsel1    = hsel_drv && dsel;
    assign hready   = dsel ? ro1 : ro0;
    assign hresp_m  = dsel ? rp1 : rp0;
    assign hrdata_m = dsel ? rd1 : rd0;

    ahb_sub_mem #(
        .MEMWORDSLOG2(8), .BASEADDR(32'h0), .NSEQWAIT(0), .SEQWAIT(0)
    ) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hwstrb(hwstrb),
        .hready(hready), .hreadyout(ro0), .hresp(rp0), .hrdata(rd0)
    );

    ahb_sub_mem #(
        .MEMWORDSLOG2(12), .BASEADDR(32'h0), .NSEQWAIT(2), .SEQWAIT(1)
    ) dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hwstrb(hwstrb),
        .hready(hready), .hreadyout(ro1), .hresp(rp1), .hrdata(rd1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic set_beat(input int i, input logic [31:0] a, input logic w,
                            input logic [1:0] t, input logic [2:0] s,
                            input logic [31:0] d, input logic [3:0] st);
        b_addr[i] = a; b_write[i] = w; b_trans[i] = t;
        b_size[i] = s; b_wdata[i] = d; b_strb[i] = st;
    endtask

    // Pipelined manager: each negedge either holds (hready low) or closes the owed
    // data phase and presents the next address phase.
    task automatic run_beats(input int n);
        int nxt = 0;
        int owed = -1;
        int cyc = 0;
        for (int i = 0; i < n; i++) begin
            r_waits[i] = 0; r_err1[i] = 1'b0; r_resp[i] = 1'b0; r_rdata[i] = '0;
        end
        while ((nxt < n || owed >= 0) && cyc < 200) begin
            @(negedge hclk);
            cyc++;
            if (owed >= 0) begin
                hwdata = b_wdata[owed];
                hwstrb = b_strb[owed];
                if (!hready) begin
                    r_waits[owed]++;
                    if (hresp_m) r_err1[owed] = 1'b1;
                    continue;
                end
                r_resp[owed]  = hresp_m;
                r_rdata[owed] = hrdata_m;
                $display("[TB] beat %0d addr=%h wr=%0d trans=%0d waits=%0d resp=%0d rdata=%h",
                         owed, b_addr[owed], b_write[owed], b_trans[owed],
                         r_waits[owed], r_resp[owed], r_rdata[owed]);
                owed = -1;
            end
            if (nxt < n) begin
                hsel_drv = 1'b1; haddr = b_addr[nxt]; htrans = b_trans[nxt];
                hwrite = b_write[nxt]; hsize = b_size[nxt];
                owed = nxt;
                nxt++;
            end else begin
                hsel_drv = 1'b0; htrans = T_IDLE; hwrite = 1'b0; hsize = SZ_WORD;
            end
        end
        tests_run++;
        if (nxt < n || owed >= 0) begin
            tests_failed++;
            $display("FAIL bus_timeout: beats issued %0d of %0d, pending=%0d", nxt, n, owed);
            hsel_drv = 1'b0; htrans = T_IDLE;
        end
    endtask

    task automatic test_reset();
        logic [2:0]  got_ctl [2];
        logic [31:0] got_rd  [2];
        hresetn = 1'b0;
        repeat (3) @(negedge hclk);
        got_ctl[0] = {ro0, rp0, 1'b0}; got_ctl[1] = {ro1, rp1, 1'b0};
        got_rd[0] = rd0; got_rd[1] = rd1;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (got_ctl[k] !== 3'b100) begin
                tests_failed++;
                $display("FAIL reset_ctl dut%0d: {hreadyout,hresp}=%b expected 10", k, got_ctl[k][2:1]);
            end
            tests_run++;
            if (got_rd[k] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_hrdata dut%0d: got %h expected 00000000", k, got_rd[k]);
            end
        end
        hresetn = 1'b1;
        $display("[TB] reset checked");
    endtask

    task automatic test_write_read();
        dsel = 1'b0;
        set_beat(0, 32'h10, 1'b1, T_NONSEQ, SZ_WORD, 32'hDEADBEEF, 4'hF);
        set_beat(1, 32'h10, 1'b0, T_NONSEQ, SZ_WORD, 32'h0, 4'h0);
        run_beats(2);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (r_waits[i] !== 0 || r_resp[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL wr_rd_okay beat%0d: waits=%0d resp=%0d expected 0/0", i, r_waits[i], r_resp[i]);
            end
        end
        tests_run++;
        if (r_rdata[1] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wr_rd_data: got %h expected deadbeef", r_rdata[1]);
        end
    endtask

    task automatic test_burst_waits();
        int          exp_w [8];
        logic [31:0] d;
        exp_w = '{2, 1, 1, 1, 2, 1, 1, 1};
        dsel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 32'hA000_0000 + 32'(i) * 32'h0101;
            set_beat(i, 32'h100 + 32'(4*i), 1'b1, (i == 0) ? T_NONSEQ : T_SEQ, SZ_WORD, d, 4'hF);
            set_beat(i + 4, 32'h100 + 32'(4*i), 1'b0, (i == 0) ? T_NONSEQ : T_SEQ, SZ_WORD, 32'h0, 4'h0);
        end
        run_beats(8);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (r_waits[i] !== exp_w[i] || r_resp[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL burst_waits beat%0d: waits=%0d resp=%0d expected %0d/0", i, r_waits[i], r_resp[i], exp_w[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            d = 32'hA000_0000 + 32'(i) * 32'h0101;
            tests_run++;
            if (r_rdata[i + 4] !== d) begin
                tests_failed++;
                $display("FAIL burst_data beat%0d: got %h expected %h", i + 4, r_rdata[i + 4], d);
            end
        end
    endtask

    task automatic test_strobes();
        dsel = 1'b0;
        set_beat(0, 32'h30, 1'b1, T_NONSEQ, SZ_WORD, 32'h11223344, 4'hF);
        set_beat(1, 32'h30, 1'b1, T_NONSEQ, SZ_WORD, 32'hAABBCCDD, 4'b0101);
        set_beat(2, 32'h30, 1'b0, T_NONSEQ, SZ_WORD, 32'h0, 4'h0);
        run_beats(3);
        tests_run++;
        if (r_rdata[2] !== 32'h11BB33DD) begin
            tests_failed++;
            $display("FAIL strobe_merge: got %h expected 11bb33dd", r_rdata[2]);
        end
    endtask

    task automatic test_out_of_range();
        dsel = 1'b0;
        set_beat(0, 32'h000, 1'b1, T_NONSEQ, SZ_WORD, 32'h12345678, 4'hF);
        set_beat(1, 32'h400, 1'b1, T_NONSEQ, SZ_WORD, 32'hFFFFFFFF, 4'hF);
        set_beat(2, 32'h400, 1'b0, T_NONSEQ, SZ_WORD, 32'h0, 4'h0);
        set_beat(3, 32'h000, 1'b0, T_NONSEQ, SZ_WORD, 32'h0, 4'h0);
        run_beats(4);
        for (int i = 1; i < 3; i++) begin
            tests_run++;
            if (r_waits[i] !== 1 || r_err1[i] !== 1'b1 || r_resp[i] !== 1'b1) begin
                tests_failed++;
                $display("FAIL range_err beat%0d: waits=%0d err1=%0d resp=%0d expected 1/1/1", i, r_waits[i], r_err1[i], r_resp[i]);
            end
        end
        tests_run++;
        if (r_rdata[2] !== 32'h0) begin
            tests_failed++;
            $display("FAIL range_hrdata: got %h expected 00000000", r_rdata[2]);
        end
        tests_run++;
        if (r_resp[3] !== 1'b0 || r_rdata[3] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL range_recover: resp=%0d data=%h expected 0/12345678", r_resp[3], r_rdata[3]);
        end
    endtask

    task automatic test_illegal_and_busy();
        logic        exp_r [10];
        logic [31:0] exp_d [3];
        exp_r = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_d = '{32'hA5A5A5A5, 32'hB6B6B6B6, 32'h5858C0C0};
        dsel = 1'b0;
        set_beat(0, 32'h058, 1'b1, T_NONSEQ, SZ_WORD, 32'h5858C0C0, 4'hF);
        set_beat(1, 32'h040, 1'b1, T_NONSEQ, SZ_HALF, 32'h99999999, 4'hF);
        set_beat(2, 32'h102, 1'b1, T_NONSEQ, SZ_WORD, 32'h77777777, 4'hF);
        set_beat(3, 32'h050, 1'b1, T_NONSEQ, SZ_WORD, 32'hA5A5A5A5, 4'hF);
        set_beat(4, 32'h054, 1'b1, T_BUSY,   SZ_WORD, 32'hFFFF0000, 4'hF);
        set_beat(5, 32'h054, 1'b1, T_SEQ,    SZ_WORD, 32'hB6B6B6B6, 4'hF);
        set_beat(6, 32'h058, 1'b1, T_BUSY,   SZ_WORD, 32'h00000000, 4'hF);
        set_beat(7, 32'h050, 1'b0, T_NONSEQ, SZ_WORD, 32'h0, 4'h0);
        set_beat(8, 32'h054, 1'b0, T_SEQ,    SZ_WORD, 32'h0, 4'h0);
        set_beat(9, 32'h058, 1'b0, T_SEQ,    SZ_WORD, 32'h0, 4'h0);
        run_beats(10);
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (r_resp[i] !== exp_r[i] || r_waits[i] !== int'(exp_r[i])) begin
                tests_failed++;
                $display("FAIL illegal_busy_resp beat%0d: resp=%0d waits=%0d expected %0d/%0d", i, r_resp[i], r_waits[i], exp_r[i], exp_r[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (r_rdata[i + 7] !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL illegal_busy_data beat%0d: got %h expected %h", i + 7, r_rdata[i + 7], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        dsel = 1'b1;
        set_beat(0, 32'h20, 1'b1, T_NONSEQ, SZ_WORD, 32'hCAFEF00D, 4'hF);
        run_beats(1);
        @(negedge hclk);
        hsel_drv = 1'b1; haddr = 32'h20; htrans = T_NONSEQ; hwrite = 1'b1; hsize = SZ_WORD;
        @(negedge hclk);
        hsel_drv = 1'b0; htrans = T_IDLE; hwdata = 32'hBAD0BAD0; hwstrb = 4'hF;
        tests_run++;
        if (hready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_wait_entry: hreadyout=%0d expected 0", hready);
        end
        #2 hresetn = 1'b0;
        #1;
        tests_run++;
        if (hready !== 1'b1 || hresp_m !== 1'b0 || hrdata_m !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_wait_outputs: ready=%0d resp=%0d rdata=%h expected 1/0/00000000", hready, hresp_m, hrdata_m);
        end
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        set_beat(0, 32'h20, 1'b0, T_NONSEQ, SZ_WORD, 32'h0, 4'h0);
        run_beats(1);
        tests_run++;
        if (r_rdata[0] !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL rst_wait_nowrite: got %h expected cafef00d", r_rdata[0]);
        end
    endtask

    initial begin
        hresetn = 1'b0; hsel_drv = 1'b0; dsel = 1'b0; haddr = '0; htrans = T_IDLE;
        hwrite = 1'b0; hsize = SZ_WORD; hburst = 3'b001; hwdata = '0; hwstrb = 4'h0;
        test_reset();
        test_write_read();
        test_burst_waits();
        test_strobes();
        test_out_of_range();
        test_illegal_and_busy();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
